// File: rtl/bp_pkg.sv
// bp_pkg: shared FSM state type and saturating-counter helpers for the gshare predictor
package bp_pkg;
  typedef enum logic {INIT, RUN} state_e;
  function automatic int ctr_init(int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction
  function automatic int sat_update(int ctr, logic taken, int ctr_w);
    int mx;
    mx = (1 << ctr_w) - 1;
    return taken ? (ctr >= mx ? mx : ctr + 1) : (ctr <= 0 ? 0 : ctr - 1);
  endfunction
endpackage

// File: rtl/bp_pht.sv
// bp_pht: pattern history table of saturating counters, async read, sync write
// Ports: rd_idx_i/rd_msb_o async read of the counter MSB; we_i/wr_idx_i write port
// that either loads the weakly-not-taken value (init_i) or trains toward taken_i.
module bp_pht import bp_pkg::*; #(
  parameter int IDX_W = 8,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_msb_o,
  input  logic             we_i,
  input  logic             init_i,
  input  logic             taken_i,
  input  logic [IDX_W-1:0] wr_idx_i
);
  logic [CTR_W-1:0] mem_q [2**IDX_W];
  assign rd_msb_o = mem_q[rd_idx_i][CTR_W-1];
  always_ff @(posedge clk)
    if (we_i)
      mem_q[wr_idx_i] <= init_i ? CTR_W'(ctr_init(CTR_W))
                                : CTR_W'(sat_update(int'(mem_q[wr_idx_i]), taken_i, CTR_W));
endmodule

// File: rtl/gshare_predictor_param.sv
// gshare_predictor_param: gshare direction predictor with speculative GHR and registered target
// Ports: clk, reset (async active-low); lookup_* request -> pred_* one cycle later;
// ready once the PHT sweep is done; resolve_* trains the PHT and repairs the GHR on mispredict.
module gshare_predictor_param import bp_pkg::*; #(
  parameter int GHR_W    = 8,
  parameter int IDX_W    = 8,
  parameter int CTR_W    = 2,
  parameter int PC_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_valid,
  input  logic             lookup_is_branch,
  input  logic [31:0]      lookup_pc,
  input  logic [31:0]      lookup_offset,
  output logic             ready,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic [IDX_W-1:0] pred_index,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic             resolve_mispredict,
  input  logic [IDX_W-1:0] resolve_index,
  input  logic [GHR_W-1:0] resolve_ghr
);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, idx;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic             run, acc, msb, taken, recover;
  assign run     = state_q == RUN;
  assign idx     = lookup_pc[PC_SHIFT +: IDX_W] ^ IDX_W'(ghr_q);
  assign acc     = run & lookup_valid;
  assign taken   = msb & lookup_is_branch;
  assign recover = run & resolve_valid & resolve_mispredict;
  assign ready   = run;
  // Shifts are written as truncated concatenations so GHR_W=1 stays legal.
  always_comb begin
    state_d = (!run && &ptr_q) ? RUN : state_q;
    ptr_d   = run ? ptr_q : ptr_q + 1'b1;
    ghr_d   = recover ? GHR_W'({resolve_ghr, resolve_taken})
            : (acc & lookup_is_branch) ? GHR_W'({ghr_q, taken}) : ghr_q;
  end
  bp_pht #(.IDX_W(IDX_W), .CTR_W(CTR_W)) u_pht (
    .clk      (clk),
    .rd_idx_i (idx),
    .rd_msb_o (msb),
    .we_i     (!run | resolve_valid),
    .init_i   (!run),
    .taken_i  (resolve_taken),
    .wr_idx_i (run ? resolve_index : ptr_q)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= INIT;
      ptr_q       <= '0;
      ghr_q       <= '0;
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      pred_index  <= '0;
      pred_ghr    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ghr_q      <= ghr_d;
      pred_valid <= acc;
      if (acc) begin
        pred_taken  <= taken;
        pred_target <= lookup_pc + lookup_offset;
        pred_index  <= idx;
        pred_ghr    <= ghr_q;
      end
    end
endmodule

// File: tb/tb_gshare_predictor_param.sv
// tb_gshare_predictor_param: random + directed bench against a behavioural gshare model
module tb_gshare_predictor_param;
  logic        clk = 0, reset = 1, lv = 0, lb = 0, rv = 0, rt = 0, rm = 0;
  logic [31:0] pc = 0, off = 0;
  logic [7:0]  ri = 0, rg = 0;
  logic        rdy, pv, pt;
  logic [31:0] ptg;
  logic [7:0]  pi, pg;
  int total = 0, bad = 0, n;
  bit armed = 0;
  bit m_run = 0;
  int m_cnt = 0, m_ghr = 0, m_ng, m_idx, m_pht[256];
  int e_v = 0, e_t = 0, e_idx = 0, e_g = 0;
  logic [31:0] e_tg = 0;

  gshare_predictor_param dut (
    .clk(clk), .reset(reset), .lookup_valid(lv), .lookup_is_branch(lb),
    .lookup_pc(pc), .lookup_offset(off), .ready(rdy), .pred_valid(pv),
    .pred_taken(pt), .pred_target(ptg), .pred_index(pi), .pred_ghr(pg),
    .resolve_valid(rv), .resolve_taken(rt), .resolve_mispredict(rm),
    .resolve_index(ri), .resolve_ghr(rg)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // Model: counters as plain ints 0..3, history as an int kept mod 256.
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_run = 0; m_cnt = 0; m_ghr = 0;
      e_v = 0; e_t = 0; e_idx = 0; e_g = 0; e_tg = 0;
    end else if (!m_run) begin
      e_v = 0;
      m_cnt++;
      if (m_cnt == 256) begin
        m_run = 1;
        foreach (m_pht[i]) m_pht[i] = 1;
      end
    end else begin
      m_ng = m_ghr;
      e_v = lv;
      if (lv) begin
        m_idx = ((pc / 4) % 256) ^ m_ghr;
        e_idx = m_idx;
        e_t = (lb && m_pht[m_idx] >= 2);
        e_tg = pc + off;
        e_g = m_ghr;
        if (lb) m_ng = (m_ghr * 2 + e_t) % 256;
      end
      if (rv) begin
        if (rt) m_pht[ri] = m_pht[ri] < 3 ? m_pht[ri] + 1 : 3;
        else m_pht[ri] = m_pht[ri] > 0 ? m_pht[ri] - 1 : 0;
        if (rm) m_ng = (rg * 2 + rt) % 256;
      end
      m_ghr = m_ng;
    end

  always @(negedge clk)
    if (armed) begin
      chk("ready", rdy, m_run);
      chk("valid", pv, e_v);
      chk("taken", pt, e_t);
      chk("target", ptg, e_tg);
      chk("index", pi, e_idx);
      chk("ghr", pg, e_g);
    end

  task automatic rnd();
    lv = $urandom_range(0, 3) != 0;
    lb = $urandom_range(0, 1) == 1;
    pc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 511)) << 2;
    off = $urandom;
    rv = $urandom_range(0, 1) == 1;
    rt = $urandom_range(0, 1) == 1;
    rm = $urandom_range(0, 7) == 0;
    ri = 8'($urandom_range(0, 255));
    rg = 8'($urandom_range(0, 255));
  endtask

  task automatic step(input logic l, input logic b, input logic [31:0] p, input logic [31:0] o,
                      input logic r, input logic t, input logic m, input logic [7:0] i, input logic [7:0] g);
    @(negedge clk);
    lv = l; lb = b; pc = p; off = o; rv = r; rt = t; rm = m; ri = i; rg = g;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Counts negedges until ready, feeding random traffic that INIT must ignore.
  task automatic wait_ready(input string nm);
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (rdy) break;
      rnd();
    end
    lv = 0; rv = 0;
    chk(nm, n, 256);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end

  initial begin
    #1 reset = 0;
    armed = 1;
    repeat (3) @(negedge clk);
    reset = 1;
    wait_ready("init_len");
    step(1, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    idle();
    chk("lit_valid", pv, 1);
    chk("lit_taken", pt, 0);
    chk("lit_index", pi, 32'h40);
    chk("lit_ghr", pg, 0);
    step(1, 0, 32'h1000, 32'hFFFFFFF0, 0, 0, 0, 0, 0);
    idle();
    chk("lit_tgt1", ptg, 32'h0FF0);
    step(1, 0, 32'hFFFFFFFC, 8, 0, 0, 0, 0, 0);
    idle();
    chk("lit_tgt2", ptg, 32'h4);
    repeat (4) step(0, 0, 0, 0, 1, 1, 0, 8'h40, 0);
    step(1, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    idle();
    chk("lit_sat_hi", pt, 1);
    repeat (4) step(0, 0, 0, 0, 1, 0, 0, 8'h40, 0);
    step(1, 1, 32'h104, 0, 0, 0, 0, 0, 0);
    idle();
    chk("lit_sat_lo_idx", pi, 32'h40);
    chk("lit_sat_lo", pt, 0);
    step(0, 0, 0, 0, 1, 0, 1, 8'h80, 8'h00);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 0, 1, 1, 0, 8'h10, 0);
      step(0, 0, 0, 0, 1, 1, 0, 8'h11, 0);
      step(0, 0, 0, 0, 1, 1, 0, 8'h13, 0);
    end
    repeat (3) step(1, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h40, 0, 1, 0, 1, 8'h90, 8'h01);
    chk("lit_third_ghr", pg, 32'h03);
    chk("lit_third_taken", pt, 1);
    idle();
    chk("lit_prerecov_ghr", pg, 32'h07);
    chk("lit_prerecov_idx", pi, 32'h17);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("lit_recov_ghr", pg, 32'h02);
    step(0, 0, 0, 0, 1, 1, 0, 8'h20, 0);
    step(1, 1, 32'h88, 0, 1, 0, 0, 8'h20, 0);
    idle();
    chk("lit_rbw_idx", pi, 32'h20);
    chk("lit_rbw_old", pt, 1);
    step(1, 1, 32'h94, 0, 0, 0, 0, 0, 0);
    idle();
    chk("lit_rbw_idx2", pi, 32'h20);
    chk("lit_rbw_new", pt, 0);
    repeat (3000) begin
      @(negedge clk);
      rnd();
    end
    step(1, 0, 32'h200, 32'h10, 0, 0, 0, 0, 0);
    idle();
    #2 reset = 0;
    #1;
    chk("async_valid", pv, 0);
    chk("async_target", ptg, 0);
    chk("async_ready", rdy, 0);
    @(negedge clk);
    reset = 1;
    repeat (100) begin
      @(negedge clk);
      rnd();
    end
    #2 reset = 0;
    #1 chk("mid_init_ready", rdy, 0);
    @(negedge clk);
    lv = 0; rv = 0;
    reset = 1;
    wait_ready("reinit_len");
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("entry_idx", pi, i - 1);
        chk("entry_ctr", pt, 0);
        chk("entry_ghr", pg, 0);
      end
      lv = i < 100; lb = 1; pc = i * 4; off = 0;
    end
    idle();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
